// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side buffering blocks.
package uart_pkg;

    localparam int UART_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } txq_state_e;

endpackage

// File: rtl/uart_fifo_if.sv
// Push/pop/head bundle between a FIFO user (master) and the circular buffer core (slave).
interface uart_fifo_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int AW = $clog2(DEPTH);

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic [AW:0]      count;

    modport master (output push, push_data, pop, input head, full, empty, count);
    modport slave  (input push, push_data, pop, output head, full, empty, count);
endinterface

// File: rtl/uart_fifo_core.sv
// Generic circular byte buffer with wrap-bit pointers and synchronous flush.
// Reusable on either side of the UART (TX buffering, RX buffering).
module uart_fifo_core #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      nReset,
    input  logic      flush,
    uart_fifo_if.slave fifo
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    // Pushes into a full buffer and pops from an empty one are silently dropped.
    assign do_push = fifo.push && !fifo.full && !flush;
    assign do_pop  = fifo.pop && !fifo.empty && !flush;

    assign fifo.empty = (wr_ptr_q == rd_ptr_q);
    assign fifo.full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign fifo.count = wr_ptr_q - rd_ptr_q;
    assign fifo.head  = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage has no reset so it maps onto plain flops/RAM; only entries behind the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= fifo.push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Host-side byte buffer feeding UartTxEn: valid/ready writes in, one frame launched at a time.
// Adds the launch FSM and a sticky overflow flag around uart_fifo_core.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_WIDTH
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       tx_data,
    output logic                   tx_valid,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   idle
);
    uart_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) fifo_bus ();

    uart_fifo_core #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .nReset (nReset),
        .flush  (flush),
        .fifo   (fifo_bus.slave)
    );

    txq_state_e       state_q, state_d;
    logic [WIDTH-1:0] tx_data_q, tx_data_d;
    logic             overflow_q, overflow_d;
    logic             pop;

    assign in_ready           = !fifo_bus.full;
    assign fifo_bus.push      = in_valid && in_ready;
    assign fifo_bus.push_data = in_data;
    assign fifo_bus.pop       = pop;

    assign count    = fifo_bus.count;
    assign tx_data  = tx_data_q;
    assign tx_valid = (state_q == LAUNCH);
    assign overflow = overflow_q;
    assign idle     = fifo_bus.empty && (state_q == IDLE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        overflow_d = overflow_q || (in_valid && !in_ready);
        unique case (state_q)
            IDLE: begin
                // Byte is captured here so tx_data is stable for the whole LAUNCH phase.
                if (!fifo_bus.empty && !tx_busy) begin
                    state_d   = LAUNCH;
                    tx_data_d = fifo_bus.head;
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    pop     = 1'b1;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A frame already in the serializer finishes on its own; its tx_done lands in IDLE and is ignored.
        if (flush) begin
            state_d    = IDLE;
            pop        = 1'b0;
            overflow_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UartTxEn stand-in (busy 1 cycle after valid, done 20 cycles later).
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk      = 1'b0;
    logic             nReset   = 1'b0;
    logic             flush    = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_busy  = 1'b0;
    logic             tx_done  = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             idle;

    logic             model_en = 1'b0;
    int unsigned      busy_cnt = 0;
    logic [WIDTH-1:0] log_q [$];

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .flush    (flush),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .count    (count),
        .overflow (overflow),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: logs every accepted byte; a started frame always runs to completion.
    always @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            busy_cnt <= 0;
        end else begin
            tx_done <= 1'b0;
            if (tx_valid && tx_busy) log_q.push_back(tx_data);
            if (tx_busy) begin
                if (busy_cnt == 19) begin
                    tx_done <= 1'b1;
                    tx_busy <= 1'b0;
                end
                busy_cnt <= busy_cnt + 1;
            end else if (model_en && tx_valid) begin
                tx_busy  <= 1'b1;
                busy_cnt <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [WIDTH-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (idle && !tx_busy) break;
            tick();
        end
        check(tag, 32'(idle && !tx_busy), 32'd1);
    endtask

    initial begin
        int base;

        // Reset values
        #12;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle",     32'(idle),     32'd1);
        check("rst_count",    32'(count),    32'd0);
        nReset = 1'b1;
        tick();

        // Single byte: 2-cycle launch latency, pop on accept edge
        model_en = 1'b1;
        base = log_q.size();
        write_byte(8'hA5);
        check("t1_count_after_write", 32'(count),    32'd1);
        check("t1_valid_not_yet",     32'(tx_valid), 32'd0);
        tick();
        check("t1_valid_rise",        32'(tx_valid), 32'd1);
        check("t1_data",              32'(tx_data),  32'hA5);
        tick();
        check("t1_valid_held",        32'(tx_valid), 32'd1);
        check("t1_count_before_acc",  32'(count),    32'd1);
        tick();
        check("t1_count_after_acc",   32'(count),    32'd0);
        check("t1_valid_drop",        32'(tx_valid), 32'd0);
        check("t1_not_idle_in_frame", 32'(idle),     32'd0);
        wait_quiet(60, "t1_idle_after_done");
        check("t1_log_size", 32'(log_q.size()), 32'(base + 1));
        check("t1_log_byte", 32'(log_q[base]),  32'hA5);

        // Fill to DEPTH with transmitter stalled, then overflow
        model_en = 1'b0;
        for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
        check("t2_count_full",   32'(count),    32'd16);
        check("t2_in_ready_low", 32'(in_ready), 32'd0);
        check("t2_launching",    32'(tx_valid), 32'd1);
        check("t2_head_data",    32'(tx_data),  32'h00);
        check("t2_no_overflow",  32'(overflow), 32'd0);
        write_byte(8'hEE);
        check("t2_overflow_set",    32'(overflow), 32'd1);
        check("t2_count_unchanged", 32'(count),    32'd16);
        tick();
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        base = log_q.size();
        model_en = 1'b1;
        wait_quiet(1000, "t2_drain");
        check("t2_log_size", 32'(log_q.size()), 32'(base + DEPTH));
        for (int i = 0; i < DEPTH; i++) check($sformatf("t2_order_%0d", i), 32'(log_q[base + i]), 32'(i));

        // Simultaneous write and accept at count=5
        model_en = 1'b0;
        base = log_q.size();
        for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i));
        check("t3_count5", 32'(count), 32'd5);
        model_en = 1'b1;
        tick();
        check("t3_busy_up", 32'(tx_busy), 32'd1);
        write_byte(8'h25);
        check("t3_count_still5", 32'(count),    32'd5);
        check("t3_valid_drop",   32'(tx_valid), 32'd0);
        wait_quiet(1000, "t3_drain");
        check("t3_log_size", 32'(log_q.size()), 32'(base + 6));
        for (int i = 0; i < 6; i++) check($sformatf("t3_order_%0d", i), 32'(log_q[base + i]), 32'h20 + 32'(i));

        // Flush in WAIT_DONE with count=3; write in the flush cycle is dropped
        base = log_q.size();
        for (int i = 0; i < 4; i++) write_byte(8'h30 + 8'(i));
        check("t4_count3",        32'(count),    32'd3);
        check("t4_in_wait_done",  32'(tx_valid), 32'd0);
        check("t4_overflow_kept", 32'(overflow), 32'd1);
        flush    = 1'b1;
        in_data  = 8'h77;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_flush_count",    32'(count),    32'd0);
        check("t4_flush_overflow", 32'(overflow), 32'd0);
        check("t4_flush_valid",    32'(tx_valid), 32'd0);
        check("t4_flush_idle",     32'(idle),     32'd1);
        wait_quiet(60, "t4_frame_finish");
        tick();
        tick();
        check("t4_done_ignored", 32'(tx_valid), 32'd0);
        write_byte(8'h44);
        wait_quiet(100, "t4_relaunch");
        check("t4_log_size",   32'(log_q.size()),   32'(base + 2));
        check("t4_log_first",  32'(log_q[base]),     32'h30);
        check("t4_log_second", 32'(log_q[base + 1]), 32'h44);

        // Asynchronous reset while in LAUNCH
        model_en = 1'b0;
        write_byte(8'h5A);
        tick();
        check("t5_launching", 32'(tx_valid), 32'd1);
        #2 nReset = 1'b0;
        #1;
        check("t5_rst_valid",    32'(tx_valid), 32'd0);
        check("t5_rst_count",    32'(count),    32'd0);
        check("t5_rst_data",     32'(tx_data),  32'h00);
        check("t5_rst_idle",     32'(idle),     32'd1);
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        #2 nReset = 1'b1;
        tick();
        check("t5_post_rst_idle", 32'(idle), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte-wide transmit buffer that sits directly upstream of UartTxEn.
- Accepts bytes from a host over a valid/ready handshake and stores them in a circular FIFO.
- Launches them one at a time into the transmitter via its data/valid/busy/done interface.
- Decouples bursty host writes from the slow baud-rate-paced serializer.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, at least 2.
- WIDTH, 8, data width in bits; must match the UartTxEn data width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- nReset  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear: empties the FIFO and returns the FSM to IDLE.
- in_data  input  WIDTH  host write byte.
- in_valid  input  1  host write request.
- in_ready  output  1  FIFO can accept a write this cycle.
- tx_data  output  WIDTH  byte presented to UartTxEn.data.
- tx_valid  output  1  to UartTxEn.valid.
- tx_busy  input  1  from UartTxEn.busy.
- tx_done  input  1  from UartTxEn.done; a one-cycle pulse at the end of a frame.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when in_valid is high while in_ready is low; cleared by flush or reset.
- idle  output  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (nReset low, asynchronous):
  - rd_ptr, wr_ptr and count go to 0; FSM goes to IDLE.
  - tx_valid=0, tx_data=0, overflow=0, in_ready=1, idle=1.
- Pointers and storage:
  - Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Empty when the pointers are equal; full when the index bits are equal and the MSBs differ.
  - Storage is a DEPTH x WIDTH register array and is not reset.
- Write:
  - in_ready = !full (combinational).
  - On a clock edge with in_valid && in_ready, the byte is stored at wr_ptr and wr_ptr increments, wrapping modulo 2*DEPTH.
- Pop: rd_ptr increments only on an accept event in the LAUNCH state (defined below).
- Simultaneous write and pop: count is unchanged. While full, a pop in the same cycle does not open in_ready; in_ready is registered-free and depends on the current full flag only.
- FSM states (encoding in uart_pkg):
  - IDLE:
    - If not empty and tx_busy==0, go to LAUNCH.
    - tx_data is registered from mem[rd_ptr] on this transition.
  - LAUNCH:
    - tx_valid=1; tx_data is held stable.
    - On the first cycle tx_busy==1 (the accept event): pop, drop tx_valid, go to WAIT_DONE.
  - WAIT_DONE:
    - tx_valid=0.
    - When tx_done==1, go to IDLE.
    - tx_done seen while already in IDLE or LAUNCH is ignored.
- Latency:
  - Write into an empty FIFO with the FSM idle gives tx_valid high 2 cycles after the write edge: write edge, then IDLE→LAUNCH edge, then tx_valid visible.
  - Back-to-back frames: after tx_done, the next tx_valid is asserted 2 cycles later.
- count tracks occupancy: +1 on write, -1 on pop, 0 on flush.
- flush:
  - Has priority over a simultaneous write and pop; the write is dropped and does not set overflow.
  - tx_valid drops the next cycle.
  - A frame already in flight in UartTxEn completes. The FSM returns to IDLE and ignores the resulting tx_done.
- Reset mid-frame: all state clears immediately; the transmitter is reset by the same nReset.
- overflow sets one cycle after the offending edge and holds until flush or reset.

Decomposition:
- uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} txq_state_e;
  - localparam UART_WIDTH = 8.
- One natural sub-module, uart_fifo_core: generic circular buffer with pointers, full/empty, count and synchronous flush, exposing push/pop/head.
- uart_tx_fifo adds the launch FSM and the overflow flag. uart_fifo_core is reusable for a future RX-side buffer after UartRxEn.

Test Plan:
- Reset, then write 0xA5 with a tx_busy model that goes high 1 cycle after tx_valid and pulses done 20 cycles later:
  - tx_valid rises 2 cycles after the write, with tx_data=0xA5.
  - count goes 1→0 on the accept edge; idle returns after tx_done.
- Burst of 16 writes 0x00..0x0F with no transmitter progress (tx_busy held low):
  - The first byte goes to LAUNCH and is not popped, so count=16 and in_ready=0.
  - A 17th in_valid sets overflow=1 and is discarded.
  - Releasing the transmitter then yields output order 0x00..0x0F.
- Loopback with BaudRateGen + UartTxEn + UartRxEn, writing 0x55, 0x00, 0xFF:
  - UartRxEn data_rx shows the same 3 bytes in order with err=0.
- Simultaneous write and accept at count=5: count stays 5 and the data order is preserved.
- flush asserted while in WAIT_DONE with count=3:
  - count=0, overflow=0, tx_valid=0.
  - The pending tx_done is ignored; the next write launches normally.
- nReset pulsed low while in LAUNCH: tx_valid=0 and count=0 immediately, without waiting for a clock edge.
